lsu_byte_serial: RTL and testbench
==================================

# lsu_byte_serial

Load/store unit between the execute stage and the byte-wide data memory. It accepts one load or store request at a time over a valid/ready handshake. It moves the data as little-endian bytes, one per clock, and returns the load result sign- or zero-extended to 32 bits with a one-cycle response pulse. It replaces direct datapath access to the memory array, so memory gets a single byte port and a clocked, checkable access sequence.

## Interface
- Parameters:
- MEM_AW, 6, byte address width of the data memory (2**MEM_AW bytes)
- Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_wr  in  1  1 = store, 0 = load
- req_ctrl  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  request rejected; valid with rsp_valid
- mem_addr  out  MEM_AW  byte address to memory
- mem_wdata  out  8  byte to write
- mem_we  out  1  byte write enable
- mem_rdata  in  8  combinational read of mem_addr

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch addr, wdata, ctrl and wr.
  - Byte count n = 1, 2 or 4 from ctrl[1:0].
- Error check at acceptance. Any of the following sets rsp_err and goes IDLE→RESP with no memory access:
  - ctrl in {011, 110, 111};
  - a store with ctrl[2]=1;
  - req_addr+n-1 ≥ 2**MEM_AW, computed in 33 bits with no wrap.
- ACCESS:
  - Byte index k runs 0..n-1, one byte per cycle; mem_addr = base+k.
  - Store: mem_we=1, mem_wdata = wdata[8k+7:8k].
  - Load: mem_rdata is captured into byte lane k at the clock edge.
  - After k=n-1, go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - Extension: B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Outside ACCESS: mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation aborts the request. Bytes already written stay written, and no response is issued.

## Timing
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_we=0; mem_addr=0; mem_wdata=0.
- Acceptance edge is E0. ACCESS occupies cycles E0..E0+n-1, and rsp_valid is high in the cycle after E(n-1).
- Response latency is n+1 cycles; the next request can be accepted in the cycle after rsp_valid.
- Error path: rsp_valid in the cycle after E0.
- req_ready is a function of state only, with no combinational path from req_valid.
- rsp_rdata and rsp_err hold their values until the next RESP.

## Configuration
- LSU_MISALIGN_TRAP_EN:
  - Defined: H/HU with addr[0]≠0, or W with addr[1:0]≠0, is an error handled on the error path above.
  - Undefined: misaligned accesses proceed byte-serially like aligned ones.

## Structure
- Package lsu_pkg:
  - funct3 enum (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101);
  - state enum;
  - function nbytes(ctrl).
- One combinational sub-module, lsu_extend (ctrl, raw 32 → extended 32), instantiated on the RESP data path.

## Test plan
- After reset, SW addr 8 wdata 0xDEADBEEF:
  - mem_we high 4 cycles writing EF, BE, AD, DE to bytes 8..11;
  - rsp_valid in cycle 5 after acceptance, rsp_rdata=0, rsp_err=0.
- LW addr 8 → rsp_rdata 0xDEADBEEF after 4 ACCESS cycles; req_ready=0 throughout.
- Loads from the same data:
  - LB addr 9 → 0xFFFFFFBE; LBU addr 9 → 0x000000BE;
  - LH addr 10 → 0xFFFFDEAD; LHU addr 10 → 0x0000DEAD.
- Errors with MEM_AW=6 (no mem_we at any point, rsp_valid one cycle after acceptance):
  - LW addr 62 → rsp_err=1, rsp_rdata=0.
  - SB with ctrl=100 → rsp_err=1.
- LH addr 3:
  - with LSU_MISALIGN_TRAP_EN → rsp_err=1;
  - without it → bytes 3 and 4 are read and the result is extended.
- Reset asserted during the 3rd ACCESS cycle of SW addr 16 data 0x11223344:
  - only bytes 16 and 17 hold 44 and 33;
  - no rsp_valid;
  - req_ready=1 after reset release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serial load/store unit.
package lsu_pkg;

   // Load encodings; stores reuse the signed ones (SB/SH/SW)
   typedef enum logic [2:0] {
      Lb  = 3'b000,
      Lh  = 3'b001,
      Lw  = 3'b010,
      Lbu = 3'b100,
      Lhu = 3'b101
   } funct3_e;

   typedef logic [1:0] state_t;
   localparam state_t StIdle   = 2'd0;
   localparam state_t StAccess = 2'd1;
   localparam state_t StResp   = 2'd2;

   function automatic logic [2:0] nbytes(input logic [1:0] size);
      case (size)
         2'b00:   nbytes = 3'd1;
         2'b01:   nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of assembled load data according to funct3.
module lsu_extend
   import lsu_pkg::*;
(
   input  logic [2:0]  ctrl_i,
   input  logic [31:0] raw_i,
   output logic [31:0] ext_o
);

   always_comb begin
      case (ctrl_i)
         Lb:      ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
         Lh:      ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
         Lbu:     ext_o = {24'b0, raw_i[7:0]};
         Lhu:     ext_o = {16'b0, raw_i[15:0]};
         default: ext_o = raw_i;
      endcase
   end

endmodule

// File: rtl/lsu_byte_serial.sv
// Byte-serial load/store unit: one request at a time, one memory byte per clock.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into errors.
module lsu_byte_serial
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_AW = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [2:0]        req_ctrl,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   input  logic [7:0]        mem_rdata
);

   state_t              state_q, state_d;
   logic [MEM_AW-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [2:0]          ctrl_q, ctrl_d;
   logic                wr_q, wr_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [31:0]         raw_q, raw_d;
   logic [31:0]         rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;

   logic [32:0]         last_addr;
   logic                req_err;
   logic                last_byte;
   logic [31:0]         raw_next;
   logic [31:0]         ext_data;

   // 33-bit end address so a request near 2**32 cannot wrap into range
   always_comb begin
      last_addr = {1'b0, req_addr} + 33'(nbytes(req_ctrl[1:0])) - 33'd1;
      req_err   = !(req_ctrl inside {Lb, Lh, Lw, Lbu, Lhu})
                  || (req_wr && req_ctrl[2])
                  || ((last_addr >> MEM_AW) != 33'd0);
`ifdef LSU_MISALIGN_TRAP_EN
      if ((req_ctrl[1:0] == 2'b01 && req_addr[0]) ||
          (req_ctrl[1:0] == 2'b10 && req_addr[1:0] != 2'b00)) begin
         req_err = 1'b1;
      end
`endif
   end

   always_comb begin
      raw_next = raw_q;
      if (state_q == StAccess && !wr_q) begin
         raw_next[{cnt_q, 3'b000} +: 8] = mem_rdata;
      end
   end

   assign last_byte = ({1'b0, cnt_q} == (nbytes(ctrl_q[1:0]) - 3'd1));

   lsu_extend u_extend (
      .ctrl_i (ctrl_q),
      .raw_i  (raw_next),
      .ext_o  (ext_data)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      ctrl_d      = ctrl_q;
      wr_d        = wr_q;
      cnt_d       = cnt_q;
      raw_d       = raw_next;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = 8'h00;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               addr_d  = req_addr[MEM_AW-1:0];
               wdata_d = req_wdata;
               ctrl_d  = req_ctrl;
               wr_d    = req_wr;
               cnt_d   = 2'd0;
               raw_d   = 32'h0;
               if (req_err) begin
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = 32'h0;
                  state_d     = StResp;
               end else begin
                  state_d = StAccess;
               end
            end
         end
         StAccess: begin
            mem_addr = addr_q + MEM_AW'(cnt_q);
            if (wr_q) begin
               mem_we    = 1'b1;
               mem_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
            end
            if (last_byte) begin
               rsp_err_d   = 1'b0;
               rsp_rdata_d = wr_q ? 32'h0 : ext_data;
               state_d     = StResp;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         wdata_q     <= 32'h0;
         ctrl_q      <= 3'b000;
         wr_q        <= 1'b0;
         cnt_q       <= 2'd0;
         raw_q       <= 32'h0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         ctrl_q      <= ctrl_d;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         raw_q       <= raw_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StResp);
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_byte_serial.sv
// Self-checking bench for lsu_byte_serial: directed cases plus random requests vs a byte-array model.
module tb_lsu_byte_serial;

   localparam int unsigned AW    = 6;
   localparam int unsigned MSIZE = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_wr;
   logic [2:0]    req_ctrl;
   logic [31:0]   req_addr, req_wdata;
   logic          rsp_valid, rsp_err;
   logic [31:0]   rsp_rdata;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata, mem_rdata;
   logic          mem_we;

   logic [7:0] mem     [MSIZE] = '{default: 8'h00};
   logic [7:0] exp_mem [MSIZE] = '{default: 8'h00};
   int errors = 0;
   int checks = 0;
   int we_cnt = 0;

   lsu_byte_serial #(.MEM_AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_ctrl  (req_ctrl),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
         we_cnt        <= we_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Reference: byte-array memory, little-endian assembly, arithmetic extension
   function automatic void model(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                                 input logic [31:0] wdata, output int n, output logic err,
                                 output logic [31:0] rd);
      longint unsigned a;
      longint          val;
      a   = longint'(addr);
      n   = (ctrl[1:0] == 2'd0) ? 1 : (ctrl[1:0] == 2'd1) ? 2 : 4;
      err = (ctrl == 3'd3 || ctrl == 3'd6 || ctrl == 3'd7) || (wr && ctrl >= 3'd4)
            || (a + longint'(n) > longint'(MSIZE));
`ifdef LSU_MISALIGN_TRAP_EN
      if ((n == 2 && a % 2 != 0) || (n == 4 && a % 4 != 0)) err = 1'b1;
`endif
      rd = 32'h0;
      if (err) return;
      if (wr) begin
         for (int i = 0; i < n; i++) exp_mem[a + longint'(i)] = 8'(wdata >> (8 * i));
      end else begin
         val = 0;
         for (int i = 0; i < n; i++) val = val + (longint'(exp_mem[a + longint'(i)]) << (8 * i));
         if (ctrl == 3'd0 && val >= 128) val = val - 256;
         if (ctrl == 3'd1 && val >= 32768) val = val - 65536;
         rd = 32'(val);
      end
   endfunction

   task automatic do_req(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] got_rd,
                         output logic got_err);
      int          n;
      logic        e_err;
      logic [31:0] e_rd;
      int          lat;
      int          we0;
      logic        busy_bad;
      model(wr, ctrl, addr, wdata, n, e_err, e_rd);
      req_valid = 1'b1;
      req_wr    = wr;
      req_ctrl  = ctrl;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      we0      = we_cnt;
      lat      = 1;
      busy_bad = 1'b0;
      while (!rsp_valid && lat < 12) begin
         if (req_ready !== 1'b0) busy_bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), e_err ? 32'd1 : 32'(n + 1));
      chk("ready_while_busy", 32'(busy_bad), 32'd0);
      chk("ready_in_resp", 32'(req_ready), 32'd0);
      chk("write_cycles", 32'(we_cnt - we0), (wr && !e_err) ? 32'(n) : 32'd0);
      chk("rsp_err", 32'(rsp_err), 32'(e_err));
      chk("rsp_rdata", rsp_rdata, e_rd);
      got_rd  = rsp_rdata;
      got_err = rsp_err;
      @(posedge clk); #1;
      chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
      chk("rdata_hold", rsp_rdata, got_rd);
      chk("ready_after", 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      logic        saw_rsp;
      int          diffs;
      logic [31:0] r_addr;

      rst       = 1'b1;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_ctrl  = 3'b000;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", 32'(mem_wdata), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Fill memory with random words
      for (int i = 0; i < 16; i++) do_req(1'b1, 3'b010, 32'(4 * i), $urandom, rd, er);

      do_req(1'b1, 3'b010, 32'd8, 32'hDEADBEEF, rd, er);
      chk("sw_rdata", rd, 32'h0);
      chk("sw_err", 32'(er), 32'd0);
      chk("sw_byte8", 32'(mem[8]), 32'hEF);
      chk("sw_byte9", 32'(mem[9]), 32'hBE);
      chk("sw_byte10", 32'(mem[10]), 32'hAD);
      chk("sw_byte11", 32'(mem[11]), 32'hDE);

      do_req(1'b0, 3'b010, 32'd8, 32'h0, rd, er);
      chk("lw8", rd, 32'hDEADBEEF);
      do_req(1'b0, 3'b000, 32'd9, 32'h0, rd, er);
      chk("lb9", rd, 32'hFFFFFFBE);
      do_req(1'b0, 3'b100, 32'd9, 32'h0, rd, er);
      chk("lbu9", rd, 32'h000000BE);
      do_req(1'b0, 3'b001, 32'd10, 32'h0, rd, er);
      chk("lh10", rd, 32'hFFFFDEAD);
      do_req(1'b0, 3'b101, 32'd10, 32'h0, rd, er);
      chk("lhu10", rd, 32'h0000DEAD);

      do_req(1'b0, 3'b010, 32'd62, 32'h0, rd, er);
      chk("lw62_err", 32'(er), 32'd1);
      chk("lw62_rdata", rd, 32'h0);
      do_req(1'b1, 3'b100, 32'd0, 32'h55, rd, er);
      chk("sbu_err", 32'(er), 32'd1);

      do_req(1'b1, 3'b000, 32'd3, 32'h34, rd, er);
      do_req(1'b1, 3'b000, 32'd4, 32'h92, rd, er);
      do_req(1'b0, 3'b001, 32'd3, 32'h0, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("lh3_err", 32'(er), 32'd1);
`else
      chk("lh3_err", 32'(er), 32'd0);
      chk("lh3_rdata", rd, 32'hFFFF9234);
`endif

      // Reset during the third byte of a store: only the first two bytes land
      do_req(1'b1, 3'b010, 32'd16, 32'hAABBCCDD, rd, er);
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_ctrl  = 3'b010;
      req_addr  = 32'd16;
      req_wdata = 32'h11223344;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst     = 1'b1;
      saw_rsp = 1'b0;
      #1;
      chk("abort_we", 32'(mem_we), 32'd0);
      repeat (2) begin
         @(posedge clk); #1;
         if (rsp_valid) saw_rsp = 1'b1;
      end
      rst = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (rsp_valid) saw_rsp = 1'b1;
      end
      chk("abort_no_rsp", 32'(saw_rsp), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd1);
      chk("abort_b16", 32'(mem[16]), 32'h44);
      chk("abort_b17", 32'(mem[17]), 32'h33);
      chk("abort_b18", 32'(mem[18]), 32'hBB);
      chk("abort_b19", 32'(mem[19]), 32'hAA);
      exp_mem[16] = 8'h44;
      exp_mem[17] = 8'h33;

      for (int i = 0; i < 40; i++) begin
         r_addr = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 66));
         do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), r_addr, $urandom, rd, er);
      end

      diffs = 0;
      for (int i = 0; i < int'(MSIZE); i++) if (mem[i] !== exp_mem[i]) diffs++;
      chk("mem_final", 32'(diffs), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
